// File: rtl/hwpe_stream_fork_eager_if.sv
// Stream handshake bundle shared by the fork's input and its outputs:
// one data/strb payload with NB_LANES independent valid/ready pairs.
interface hwpe_stream_fork_eager_if #(
    parameter int unsigned NB_LANES   = 1,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NB_LANES-1:0]     valid;
    logic [NB_LANES-1:0]     ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport master (output valid, output data, output strb, input ready);
    modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_fork_eager.sv
// Eager stream fork: one buffered input beat is offered to NB_STREAMS consumers,
// each takes it independently, and the beat retires once every consumer has it.
module hwpe_stream_fork_eager #(
    parameter int unsigned NB_STREAMS = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     test_mode_i,
    hwpe_stream_fork_eager_if.slave  push_i,
    hwpe_stream_fork_eager_if.master pop_o,
    output logic [NB_STREAMS-1:0]    served_o,
    output logic                     busy_o
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_data;
    logic [STRB_WIDTH-1:0] r_strb;
    logic [NB_STREAMS-1:0] r_served;

    logic [NB_STREAMS-1:0] w_pop_valid;
    logic [NB_STREAMS-1:0] w_fire;
    logic                  w_done;
    logic                  w_push_ready;
    logic                  w_load;
    logic                  w_unused;

    assign w_unused = test_mode_i;

    // Handshake decode: per-output fire, retire condition and input acceptance.
    always_comb begin
        w_pop_valid  = {NB_STREAMS{r_full}} & ~r_served;
        w_fire       = w_pop_valid & pop_o.ready;
        w_done       = r_full & (&(r_served | w_fire));
        w_push_ready = ~r_full | w_done;
        w_load       = push_i.valid[0] & w_push_ready;
    end

    // Buffer and served-mask update; a load in the retire cycle keeps 1 beat/cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_full   <= 1'b0;
            r_data   <= {DATA_WIDTH{1'b0}};
            r_strb   <= {STRB_WIDTH{1'b0}};
            r_served <= {NB_STREAMS{1'b0}};
        end else if (w_load) begin
            r_full   <= 1'b1;
            r_data   <= push_i.data;
            r_strb   <= push_i.strb;
            r_served <= {NB_STREAMS{1'b0}};
        end else if (w_done) begin
            r_full   <= 1'b0;
            r_data   <= r_data;
            r_strb   <= r_strb;
            r_served <= {NB_STREAMS{1'b0}};
        end else if (r_full) begin
            r_full   <= 1'b1;
            r_data   <= r_data;
            r_strb   <= r_strb;
            r_served <= r_served | w_fire;
        end else begin
            r_full   <= r_full;
            r_data   <= r_data;
            r_strb   <= r_strb;
            r_served <= r_served;
        end
    end

    assign pop_o.valid  = w_pop_valid;
    assign pop_o.data   = r_data;
    assign pop_o.strb   = r_strb;
    assign push_i.ready = w_push_ready;
    assign served_o     = r_served;
    assign busy_o       = r_full;

    // Consistency and upstream protocol checks; no effect on the synthesized logic.
    a_no_valid_when_served : assert property (@(posedge clk_i) disable iff (rst_i)
        ((w_pop_valid & r_served) == {NB_STREAMS{1'b0}}))
        else $error("pop valid asserted on a served output");

    a_busy_is_full : assert property (@(posedge clk_i) disable iff (rst_i)
        (busy_o == r_full))
        else $error("busy_o differs from buffer state");

    a_push_stable : assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
        (push_i.valid[0] && !w_push_ready) |=>
        (push_i.valid[0] && $stable(push_i.data) && $stable(push_i.strb)))
        else $error("push beat dropped or changed while stalled");

endmodule

// File: tb/tb_hwpe_stream_fork_eager.sv
// Scoreboard bench for the eager fork: NB=2 instance for directed cases,
// NB=4 instance for a long sequence under per-output ready patterns.
module tb_hwpe_stream_fork_eager;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clr, tm;
    logic [1:0] served2;
    logic [3:0] served4;
    logic busy2, busy4;

    hwpe_stream_fork_eager_if #(.NB_LANES(1), .DATA_WIDTH(DW)) in2  ();
    hwpe_stream_fork_eager_if #(.NB_LANES(2), .DATA_WIDTH(DW)) out2 ();
    hwpe_stream_fork_eager_if #(.NB_LANES(1), .DATA_WIDTH(DW)) in4  ();
    hwpe_stream_fork_eager_if #(.NB_LANES(4), .DATA_WIDTH(DW)) out4 ();

    hwpe_stream_fork_eager #(.NB_STREAMS(2), .DATA_WIDTH(DW)) dut2 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .test_mode_i(tm),
        .push_i(in2), .pop_o(out2), .served_o(served2), .busy_o(busy2));

    hwpe_stream_fork_eager #(.NB_STREAMS(4), .DATA_WIDTH(DW)) dut4 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .test_mode_i(tm),
        .push_i(in4), .pop_o(out4), .served_o(served4), .busy_o(busy4));

    int total = 0;
    int bad   = 0;
    logic [35:0] sb2 [2][$];
    logic [35:0] sb4 [4][$];
    int cnt4 [4];
    int w;
    int w4;
    logic t6_done;

    function automatic logic [3:0] mkstrb(input logic [31:0] d);
        return d[3:0] ^ d[7:4] ^ 4'hA;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor for the NB=2 instance: every output handshake pops that lane's queue.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (out2.valid[i] === 1'b1 && out2.ready[i] === 1'b1) begin
                if (sb2[i].size() == 0) begin
                    total++; bad++;
                    $display("FAIL out2_lane%0d unexpected beat got=%h", i, out2.data);
                end else begin
                    check($sformatf("out2_lane%0d", i), {28'h0, out2.strb, out2.data}, {28'h0, sb2[i].pop_front()});
                end
            end
        end
    end

    // Monitor for the NB=4 instance.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (out4.valid[i] === 1'b1 && out4.ready[i] === 1'b1) begin
                cnt4[i]++;
                if (sb4[i].size() == 0) begin
                    total++; bad++;
                    $display("FAIL out4_lane%0d unexpected beat got=%h", i, out4.data);
                end else begin
                    check($sformatf("out4_lane%0d", i), {28'h0, out4.strb, out4.data}, {28'h0, sb4[i].pop_front()});
                end
            end
        end
    end

    // Offer one beat to dut2; expected copies are queued when it is accepted.
    task automatic push2(input logic [31:0] d, output int waits);
        in2.valid = 1'b1; in2.data = d; in2.strb = mkstrb(d);
        waits = 0;
        @(negedge clk);
        while (in2.ready !== 1'b1 && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (in2.ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL push2_timeout got=stalled exp=accepted data=%h", d);
        end else begin
            sb2[0].push_back({mkstrb(d), d});
            sb2[1].push_back({mkstrb(d), d});
        end
        @(posedge clk); #1;
        in2.valid = 1'b0;
    endtask

    task automatic push4(input logic [31:0] d, output int waits);
        in4.valid = 1'b1; in4.data = d; in4.strb = mkstrb(d);
        waits = 0;
        @(negedge clk);
        while (in4.ready !== 1'b1 && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        if (in4.ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL push4_timeout got=stalled exp=accepted data=%h", d);
        end else begin
            for (int i = 0; i < 4; i++) sb4[i].push_back({mkstrb(d), d});
        end
        @(posedge clk); #1;
        in4.valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; tm = 1'b0; t6_done = 1'b0;
        in2.valid = 1'b0; in2.data = 32'h0; in2.strb = 4'h0; out2.ready = 2'b00;
        in4.valid = 1'b0; in4.data = 32'h0; in4.strb = 4'h0; out4.ready = 4'h0;
        for (int i = 0; i < 4; i++) cnt4[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy2",   {63'h0, busy2}, 64'h0);
        check("reset_valid2",  {62'h0, out2.valid}, 64'h0);
        check("reset_served2", {62'h0, served2}, 64'h0);
        check("reset_ready2",  {63'h0, in2.ready}, 64'h1);
        check("reset_valid4",  {60'h0, out4.valid}, 64'h0);
        check("reset_busy4",   {63'h0, busy4}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: back-to-back beats with both outputs ready
        out2.ready = 2'b11;
        push2(32'hA1, w);
        check("t1_wait_a1", w, 0);
        check("t1_latency_valid", {62'h0, out2.valid}, 64'h3);
        push2(32'hA2, w);
        check("t1_wait_a2", w, 0);
        push2(32'hA3, w);
        check("t1_wait_a3", w, 0);
        repeat (3) @(posedge clk); #1;
        check("t1_drain0", sb2[0].size(), 0);
        check("t1_drain1", sb2[1].size(), 0);

        // T2: output 1 stalls, output 0 served once, push blocked until output 1 fires
        out2.ready = 2'b01;
        push2(32'h55, w);
        check("t2_valid_both", {62'h0, out2.valid}, 64'h3);
        @(negedge clk);
        check("t2_ready_first", {63'h0, in2.ready}, 64'h0);
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t2_served", {62'h0, served2}, 64'h1);
            check("t2_valid_out1_only", {62'h0, out2.valid}, 64'h2);
            check("t2_push_blocked", {63'h0, in2.ready}, 64'h0);
            @(posedge clk); #1;
        end
        out2.ready = 2'b11;
        @(negedge clk);
        check("t2_ready_on_fire", {63'h0, in2.ready}, 64'h1);
        @(posedge clk); #1;
        check("t2_idle_busy", {63'h0, busy2}, 64'h0);
        check("t2_idle_served", {62'h0, served2}, 64'h0);
        check("t2_drain0", sb2[0].size(), 0);
        check("t2_drain1", sb2[1].size(), 0);

        // T3: out1 takes 0x10 first, out0 later; 0x20 loads in out0's fire cycle
        out2.ready = 2'b10;
        push2(32'h10, w);
        @(posedge clk); #1;
        check("t3_served_out1", {62'h0, served2}, 64'h2);
        check("t3_valid_out0", {62'h0, out2.valid}, 64'h1);
        fork
            push2(32'h20, w);
            begin
                @(posedge clk); #1;
                out2.ready = 2'b11;
            end
        join
        check("t3_wait_20", w, 1);
        check("t3_valid_20", {62'h0, out2.valid}, 64'h3);
        check("t3_data_20", {32'h0, out2.data}, 64'h20);
        check("t3_served_20", {62'h0, served2}, 64'h0);
        repeat (3) @(posedge clk); #1;
        check("t3_drain0", sb2[0].size(), 0);
        check("t3_drain1", sb2[1].size(), 0);

        // T4: clear drops a partially served beat
        out2.ready = 2'b01;
        push2(32'h77, w);
        @(posedge clk); #1;
        check("t4_served_pre", {62'h0, served2}, 64'h1);
        clr = 1'b1;
        sb2[1].delete();
        @(posedge clk); #1;
        clr = 1'b0;
        check("t4_busy",   {63'h0, busy2}, 64'h0);
        check("t4_valid",  {62'h0, out2.valid}, 64'h0);
        check("t4_served", {62'h0, served2}, 64'h0);
        check("t4_data",   {28'h0, out2.strb, out2.data}, 64'h0);
        out2.ready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_no_replay", {62'h0, out2.valid}, 64'h0);
        end
        @(posedge clk); #1;
        check("t4_drain0", sb2[0].size(), 0);

        // T5: reset with a held beat and a pending push, then normal traffic
        out2.ready = 2'b00;
        push2(32'h31, w);
        in2.valid = 1'b1; in2.data = 32'h32; in2.strb = mkstrb(32'h32);
        @(negedge clk);
        check("t5_pending_stall", {63'h0, in2.ready}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        in2.valid = 1'b0;
        sb2[0].delete();
        sb2[1].delete();
        @(posedge clk); #1;
        check("t5_valid_idle", {62'h0, out2.valid}, 64'h0);
        check("t5_busy_idle",  {63'h0, busy2}, 64'h0);
        check("t5_served_idle", {62'h0, served2}, 64'h0);
        rst = 1'b0;
        out2.ready = 2'b11;
        push2(32'h33, w);
        check("t5_wait_33", w, 0);
        check("t5_valid_33", {62'h0, out2.valid}, 64'h3);
        check("t5_data_33", {32'h0, out2.data}, 64'h33);
        repeat (3) @(posedge clk); #1;
        check("t5_drain0", sb2[0].size(), 0);
        check("t5_drain1", sb2[1].size(), 0);

        // T6: 200 beats into the 4-output fork with per-output random ready
        fork
            begin
                for (int k = 0; k < 200; k++)
                    push4(32'hC0DE_0000 ^ (k * 32'h0101_0111), w4);
                t6_done = 1'b1;
            end
            begin
                while (t6_done !== 1'b1) begin
                    @(posedge clk); #1;
                    out4.ready = 4'($urandom_range(0, 15));
                end
            end
        join
        out4.ready = 4'hF;
        repeat (10) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_count_lane%0d", i), cnt4[i], 200);
            check($sformatf("t6_drain_lane%0d", i), sb4[i].size(), 0);
        end
        check("t6_idle", {63'h0, busy4}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
